// File: rtl/gpr_wb_queue.sv
// In-order write-back queue that buffers GPR results from long-latency units and drains them into idle GPR write-port cycles.
// Optional operand forwarding from queued entries is enabled by defining GPR_WBQ_FWD_EN.
`ifndef GPR_AddrWidth
`define GPR_AddrWidth 5
`endif
`ifndef GPR_DataWidth
`define GPR_DataWidth 32
`endif

module gpr_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [`GPR_AddrWidth-1:0] push_addr,
    input  logic [`GPR_DataWidth-1:0] push_data,
    input  logic                      gpr_wstall,
    output logic                      gpr_we,
    output logic [`GPR_AddrWidth-1:0] gpr_waddr,
    output logic [`GPR_DataWidth-1:0] gpr_wdata,
    input  logic [`GPR_AddrWidth-1:0] lk1_addr,
    input  logic [`GPR_AddrWidth-1:0] lk2_addr,
    output logic                      lk1_hit,
    output logic                      lk2_hit,
    output logic [`GPR_DataWidth-1:0] lk1_data,
    output logic [`GPR_DataWidth-1:0] lk2_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]             head_r;
    logic [PW-1:0]             tail_r;
    logic [CW-1:0]             count_r;
    logic [`GPR_AddrWidth-1:0] addr_mem_r [DEPTH];
    logic [`GPR_DataWidth-1:0] data_mem_r [DEPTH];

    logic push_ready_s;
    logic push_s;
    logic pop_s;
    logic not_empty_s;

    assign not_empty_s  = (count_r != CW'(0));
    assign push_ready_s = !rst && (count_r < CW'(DEPTH));
    // Writes to r0 complete the handshake but are dropped: r0 is hardwired zero.
    assign push_s       = push_valid && push_ready_s && (push_addr != `GPR_AddrWidth'(0));
    assign pop_s        = !rst && not_empty_s && !gpr_wstall;

    assign push_ready = push_ready_s;
    assign gpr_we     = pop_s;
    assign gpr_waddr  = not_empty_s ? addr_mem_r[head_r] : `GPR_AddrWidth'(0);
    assign gpr_wdata  = not_empty_s ? data_mem_r[head_r] : `GPR_DataWidth'(0);
    assign count      = count_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= PW'(0);
            tail_r  <= PW'(0);
            count_r <= CW'(0);
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[tail_r] <= push_addr;
            data_mem_r[tail_r] <= push_data;
        end
    end

`ifdef GPR_WBQ_FWD_EN
    logic                      lk1_hit_s;
    logic                      lk2_hit_s;
    logic [`GPR_DataWidth-1:0] lk1_data_s;
    logic [`GPR_DataWidth-1:0] lk2_data_s;

    // Scan oldest to youngest so the youngest match overrides; the entry popping now is still valid.
    always_comb begin
        logic m1;
        logic m2;
        m1         = 1'b0;
        m2         = 1'b0;
        lk1_hit_s  = 1'b0;
        lk2_hit_s  = 1'b0;
        lk1_data_s = `GPR_DataWidth'(0);
        lk2_data_s = `GPR_DataWidth'(0);
        for (int k = 0; k < DEPTH; k++) begin
            m1 = (CW'(k) < count_r) && (lk1_addr != `GPR_AddrWidth'(0)) &&
                 (addr_mem_r[head_r + PW'(k)] == lk1_addr);
            m2 = (CW'(k) < count_r) && (lk2_addr != `GPR_AddrWidth'(0)) &&
                 (addr_mem_r[head_r + PW'(k)] == lk2_addr);
            lk1_hit_s  = lk1_hit_s | m1;
            lk2_hit_s  = lk2_hit_s | m2;
            lk1_data_s = m1 ? data_mem_r[head_r + PW'(k)] : lk1_data_s;
            lk2_data_s = m2 ? data_mem_r[head_r + PW'(k)] : lk2_data_s;
        end
    end

    assign lk1_hit  = lk1_hit_s;
    assign lk2_hit  = lk2_hit_s;
    assign lk1_data = lk1_data_s;
    assign lk2_data = lk2_data_s;
`else
    assign lk1_hit  = 1'b0;
    assign lk2_hit  = 1'b0;
    assign lk1_data = `GPR_DataWidth'(0);
    assign lk2_data = `GPR_DataWidth'(0);
`endif

endmodule
